// File: rtl/hack_cpu_ctrl.sv
// hack_cpu_ctrl: multi-cycle Hack CPU control and datapath stage wrapped around an external ALU.
// Fetches instructions, decodes them and holds A, D, the M read buffer, IR and PC.
// The external ALU is fed continuously. Its result is committed only in the EXEC state.
//
// Ports
//   i_clk, i_rst_n      clock; synchronous active-low reset
//   o_imem_*/i_imem_*   instruction fetch req/ack handshake (addr = PC)
//   o_dmem_*/i_dmem_*   data read/write req/ack handshake
//   o_alu_x/o_alu_y     ALU operands (x = D, y = M buffer or A, selected by IR[12])
//   o_alu_zx..o_alu_no  ALU control bits taken straight from IR[11:6]
//   i_alu_out/zr/ng     ALU result and flags
//   o_instr_done        single-cycle pulse when an instruction retires
module hack_cpu_ctrl #(
  parameter int unsigned PC_W     = 15,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  output logic            o_imem_req,
  output logic [PC_W-1:0] o_imem_addr,
  input  logic            i_imem_ack,
  input  logic [15:0]     i_imem_rdata,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [14:0]     o_dmem_addr,
  output logic [15:0]     o_dmem_wdata,
  input  logic            i_dmem_ack,
  input  logic [15:0]     i_dmem_rdata,
  output logic [15:0]     o_alu_x,
  output logic [15:0]     o_alu_y,
  output logic            o_alu_zx,
  output logic            o_alu_nx,
  output logic            o_alu_zy,
  output logic            o_alu_ny,
  output logic            o_alu_f,
  output logic            o_alu_no,
  input  logic [15:0]     i_alu_out,
  input  logic            i_alu_zr,
  input  logic            i_alu_ng,
  output logic            o_instr_done
);

  localparam logic [1:0] ST_FETCH  = 2'd0;
  localparam logic [1:0] ST_MREAD  = 2'd1;
  localparam logic [1:0] ST_EXEC   = 2'd2;
  localparam logic [1:0] ST_MWRITE = 2'd3;

  logic [1:0]      r_state;
  logic [15:0]     r_a;
  logic [15:0]     r_d;
  logic [15:0]     r_mbuf;
  logic [15:0]     r_ir;
  logic [PC_W-1:0] r_pc;
  logic [14:0]     r_waddr;
  logic [15:0]     r_wdata;

  logic [1:0]      w_state_d;
  logic [PC_W-1:0] w_pc_inc;
  logic            w_jmp;

  assign w_pc_inc = r_pc + PC_W'(1);

  // Jump condition is evaluated on the ALU flags of the instruction in IR.
  assign w_jmp = (r_ir[2] & i_alu_ng) | (r_ir[1] & i_alu_zr) | (r_ir[0] & ~i_alu_zr & ~i_alu_ng);

  always_comb begin
    w_state_d = r_state;
    case (r_state)
      ST_FETCH: begin
        if (i_imem_ack) begin
          // Only C-instructions with the a-bit set need the M operand fetched first.
          w_state_d = (i_imem_rdata[15] && i_imem_rdata[12]) ? ST_MREAD : ST_EXEC;
        end
      end
      ST_MREAD: begin
        if (i_dmem_ack) w_state_d = ST_EXEC;
      end
      ST_EXEC: begin
        w_state_d = (r_ir[15] && r_ir[3]) ? ST_MWRITE : ST_FETCH;
      end
      ST_MWRITE: begin
        if (i_dmem_ack) w_state_d = ST_FETCH;
      end
      default: w_state_d = ST_FETCH;
    endcase
  end

  // Requests are masked while reset is held so nothing is issued before the FSM restarts.
  assign o_imem_req   = i_rst_n && (r_state == ST_FETCH);
  assign o_imem_addr  = r_pc;
  assign o_dmem_req   = i_rst_n && ((r_state == ST_MREAD) || (r_state == ST_MWRITE));
  assign o_dmem_we    = i_rst_n && (r_state == ST_MWRITE);
  assign o_dmem_addr  = (r_state == ST_MWRITE) ? r_waddr : r_a[14:0];
  assign o_dmem_wdata = r_wdata;
  assign o_instr_done = i_rst_n &&
                        (((r_state == ST_EXEC) && (w_state_d == ST_FETCH)) ||
                         ((r_state == ST_MWRITE) && i_dmem_ack));

  assign o_alu_x  = r_d;
  assign o_alu_y  = r_ir[12] ? r_mbuf : r_a;
  assign o_alu_zx = r_ir[11];
  assign o_alu_nx = r_ir[10];
  assign o_alu_zy = r_ir[9];
  assign o_alu_ny = r_ir[8];
  assign o_alu_f  = r_ir[7];
  assign o_alu_no = r_ir[6];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_FETCH;
      r_a     <= '0;
      r_d     <= '0;
      r_mbuf  <= '0;
      r_ir    <= '0;
      r_pc    <= PC_W'(RESET_PC);
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_d;
      case (r_state)
        ST_FETCH: begin
          if (i_imem_ack) r_ir <= i_imem_rdata;
        end
        ST_MREAD: begin
          if (i_dmem_ack) r_mbuf <= i_dmem_rdata;
        end
        ST_EXEC: begin
          if (!r_ir[15]) begin
            r_a  <= {1'b0, r_ir[14:0]};
            r_pc <= w_pc_inc;
          end else begin
            // Non-blocking updates: write address and jump target both see the pre-EXEC A.
            if (r_ir[5]) r_a <= i_alu_out;
            if (r_ir[4]) r_d <= i_alu_out;
            r_pc <= w_jmp ? r_a[PC_W-1:0] : w_pc_inc;
            if (r_ir[3]) begin
              r_waddr <= r_a[14:0];
              r_wdata <= i_alu_out;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
module tb_hack_cpu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req, imem_ack;
  logic [14:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [14:0] dmem_addr;
  logic [15:0] dmem_wdata, dmem_rdata;
  logic [15:0] alu_x, alu_y, alu_out;
  logic        zx, nx, zy, ny, f, no, alu_zr, alu_ng;
  logic        instr_done;

  hack_cpu_ctrl #(.PC_W(15), .RESET_PC(0)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .o_imem_req(imem_req), .o_imem_addr(imem_addr), .i_imem_ack(imem_ack),
    .i_imem_rdata(imem_rdata),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
    .o_dmem_wdata(dmem_wdata), .i_dmem_ack(dmem_ack), .i_dmem_rdata(dmem_rdata),
    .o_alu_x(alu_x), .o_alu_y(alu_y),
    .o_alu_zx(zx), .o_alu_nx(nx), .o_alu_zy(zy), .o_alu_ny(ny), .o_alu_f(f), .o_alu_no(no),
    .i_alu_out(alu_out), .i_alu_zr(alu_zr), .i_alu_ng(alu_ng),
    .o_instr_done(instr_done)
  );

  always #5 clk = ~clk;

  // Hack ALU: c = {zx,nx,zy,ny,f,no}
  function automatic logic [15:0] alu_f(logic [5:0] c, logic [15:0] x, logic [15:0] y);
    logic [15:0] a, b, o;
    a = c[5] ? 16'h0 : x;
    a = c[4] ? ~a : a;
    b = c[3] ? 16'h0 : y;
    b = c[2] ? ~b : b;
    o = c[1] ? (a + b) : (a & b);
    return c[0] ? ~o : o;
  endfunction

  // Power-on contents of data memory (address 50 holds a known word).
  function automatic logic [15:0] pat(logic [14:0] a);
    logic [15:0] v;
    v = ({1'b0, a} * 16'h9E37) ^ 16'h5A5A;
    return (a == 15'd50) ? 16'h1234 : v;
  endfunction

  always_comb begin
    alu_out = alu_f({zx, nx, zy, ny, f, no}, alu_x, alu_y);
    alu_zr  = (alu_out == 16'h0);
    alu_ng  = alu_out[15];
  end

  // ---------------- memory models ----------------
  logic [15:0] imem [0:32767];
  logic [15:0] dmem_v [0:32767];
  int          dmem_g [0:32767];
  int          epoch = 1;
  int          idly = 0, ddly = 0, icnt = 0, dcnt = 0;
  logic        spur = 1'b0, dclr = 1'b0;
  logic [31:0] cyc = 0;
  int          nwr = 0, nrd = 0;
  logic [14:0] wl_a [0:4095];
  logic [15:0] wl_d [0:4095];
  logic [14:0] last_raddr = '0;

  always_comb begin
    imem_ack   = imem_req && (icnt >= idly);
    // Garbage that changes every cycle until the ack cycle.
    imem_rdata = imem_ack ? imem[imem_addr] : (16'hA5C3 ^ cyc[15:0]);
    dmem_ack   = (dmem_req && (dcnt >= ddly)) || spur;
    dmem_rdata = (dmem_req && dmem_ack) ?
                 ((dmem_g[dmem_addr] == epoch) ? dmem_v[dmem_addr] : pat(dmem_addr)) :
                 (16'h3C96 ^ cyc[15:0]);
  end

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
    dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
    if (dclr) epoch <= epoch + 1;
    if (dmem_req && dmem_ack) begin
      if (dmem_we) begin
        dmem_v[dmem_addr] <= dmem_wdata;
        dmem_g[dmem_addr] <= epoch;
        wl_a[nwr[11:0]]   <= dmem_addr;
        wl_d[nwr[11:0]]   <= dmem_wdata;
        nwr               <= nwr + 1;
      end else begin
        nrd        <= nrd + 1;
        last_raddr <= dmem_addr;
      end
    end
  end

  // Handshake hold monitor: request signals must not move while waiting for ack.
  int          iviol = 0, dviol = 0;
  logic        ipend = 1'b0, dpend = 1'b0;
  logic [14:0] ihold = '0;
  logic [31:0] dhold = '0;
  always @(negedge clk) begin
    if (imem_req && ipend && (imem_addr !== ihold)) iviol <= iviol + 1;
    if (dmem_req && dpend && ({dmem_we, dmem_addr, dmem_wdata} !== dhold)) dviol <= dviol + 1;
    ipend <= imem_req && !imem_ack;
    ihold <= imem_addr;
    dpend <= dmem_req && !dmem_ack;
    dhold <= {dmem_we, dmem_addr, dmem_wdata};
  end

  // ---------------- checking ----------------
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Instruction-level reference model.
  logic [15:0] ma, md;
  logic [14:0] mpc;
  logic [15:0] mdm [int];
  logic        m_wrote;
  logic [14:0] m_wa;
  logic [15:0] m_wd;

  function automatic logic [15:0] mrd(logic [14:0] a);
    return mdm.exists(int'(a)) ? mdm[int'(a)] : pat(a);
  endfunction

  task automatic model_step();
    logic [15:0] ins, y, o, old_a;
    logic        take;
    ins     = imem[mpc];
    m_wrote = 1'b0;
    if (!ins[15]) begin
      ma  = {1'b0, ins[14:0]};
      mpc = mpc + 15'd1;
    end else begin
      y     = ins[12] ? mrd(ma[14:0]) : ma;
      o     = alu_f(ins[11:6], md, y);
      take  = (ins[2] && $signed(o) < 0) || (ins[1] && o == 16'h0) ||
              (ins[0] && $signed(o) > 0);
      old_a = ma;
      if (ins[3]) begin
        mdm[int'(old_a[14:0])] = o;
        m_wrote = 1'b1;
        m_wa    = old_a[14:0];
        m_wd    = o;
      end
      if (ins[5]) ma = o;
      if (ins[4]) md = o;
      mpc = take ? old_a[14:0] : mpc + 15'd1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    dclr  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dclr  = 1'b0;
  endtask

  // Wait for one retirement; returns just after the committing edge.
  task automatic step_one(input bit use_model, output bit ok);
    int k;
    k  = 0;
    ok = 1'b0;
    while (!ok && k < 100) begin
      @(negedge clk);
      k++;
      if (instr_done) begin
        if (use_model) model_step();
        @(posedge clk);
        #1;
        ok = 1'b1;
      end
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL step_timeout: instr_done absent for 100 cycles, expected a retirement");
    end
  endtask

  typedef struct {
    string       name;
    logic [15:0] p0, p1, p2, p3, hi;
    int          n, idl, ddl;
    logic [15:0] ea, ed;
    logic [14:0] epc;
    int          enw;
    logic [14:0] ewa;
    logic [15:0] ewd;
    int          enr;
    logic [14:0] era;
  } vec_t;

  vec_t vt [8];

  initial begin
    bit ok;
    int nwr0, nrd0, w;
    for (int i = 0; i < 32768; i++) imem[i] = 16'h0;

    vt[0] = '{"store7", 16'h0007, 16'hEC10, 16'h0064, 16'hE308, 16'h0, 4, 0, 0,
              16'd100, 16'd7, 15'd4, 1, 15'd100, 16'd7, 0, 15'd0};
    vt[1] = '{"store7_slow", 16'h0007, 16'hEC10, 16'h0064, 16'hE308, 16'h0, 4, 3, 1,
              16'd100, 16'd7, 15'd4, 1, 15'd100, 16'd7, 0, 15'd0};
    vt[2] = '{"jgt_taken", 16'h0007, 16'hEC10, 16'h0014, 16'hE301, 16'h0, 4, 1, 0,
              16'd20, 16'd7, 15'd20, 0, 15'd0, 16'd0, 0, 15'd0};
    vt[3] = '{"jgt_not", 16'h0000, 16'hEC10, 16'h0014, 16'hE301, 16'h0, 4, 0, 0,
              16'd20, 16'd0, 15'd4, 0, 15'd0, 16'd0, 0, 15'd0};
    vt[4] = '{"jmp", 16'h0003, 16'hEA87, 16'h0000, 16'h0000, 16'h0, 2, 2, 0,
              16'd3, 16'd0, 15'd3, 0, 15'd0, 16'd0, 0, 15'd0};
    vt[5] = '{"d_eq_m", 16'h0032, 16'hFC10, 16'h0000, 16'h0000, 16'h0, 2, 0, 2,
              16'd50, 16'h1234, 15'd2, 0, 15'd0, 16'd0, 1, 15'd50};
    vt[6] = '{"am_dplus1", 16'h0005, 16'hEC10, 16'h000A, 16'hE7E8, 16'h0, 4, 1, 1,
              16'd6, 16'd5, 15'd4, 1, 15'd10, 16'd6, 0, 15'd0};
    vt[7] = '{"pc_wrap", 16'h7FFF, 16'hEA87, 16'h0000, 16'h0000, 16'h0005, 3, 0, 0,
              16'd5, 16'd0, 15'd0, 0, 15'd0, 16'd0, 0, 15'd0};

    // Reset state while reset is held.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.imem_req", 32'(imem_req), 0);
    chk("rst.dmem_req", 32'(dmem_req), 0);
    chk("rst.instr_done", 32'(instr_done), 0);
    chk("rst.A", 32'(dut.r_a), 0);
    chk("rst.D", 32'(dut.r_d), 0);
    chk("rst.PC", 32'(dut.r_pc), 0);

    // ---- table-driven programs ----
    foreach (vt[i]) begin
      for (int a = 0; a < 32; a++) imem[a] = 16'h0;
      imem[0] = vt[i].p0; imem[1] = vt[i].p1; imem[2] = vt[i].p2; imem[3] = vt[i].p3;
      imem[32767] = vt[i].hi;
      idly = vt[i].idl;
      ddly = vt[i].ddl;
      do_reset();
      nwr0 = nwr;
      nrd0 = nrd;
      ok   = 1'b1;
      for (int s = 0; s < vt[i].n && ok; s++) step_one(1'b0, ok);
      chk({vt[i].name, ".A"}, 32'(dut.r_a), 32'(vt[i].ea));
      chk({vt[i].name, ".D"}, 32'(dut.r_d), 32'(vt[i].ed));
      chk({vt[i].name, ".PC"}, 32'(dut.r_pc), 32'(vt[i].epc));
      chk({vt[i].name, ".nwrites"}, 32'(nwr - nwr0), 32'(vt[i].enw));
      chk({vt[i].name, ".nreads"}, 32'(nrd - nrd0), 32'(vt[i].enr));
      if (vt[i].enw > 0) begin
        w = nwr - 1;
        chk({vt[i].name, ".waddr"}, 32'(wl_a[w[11:0]]), 32'(vt[i].ewa));
        chk({vt[i].name, ".wdata"}, 32'(wl_d[w[11:0]]), 32'(vt[i].ewd));
      end
      if (vt[i].enr > 0) chk({vt[i].name, ".raddr"}, 32'(last_raddr), 32'(vt[i].era));
    end

    // ---- spurious dmem_ack while no data request is pending ----
    for (int a = 0; a < 32; a++) imem[a] = 16'h0;
    imem[0] = 16'h0007; imem[1] = 16'hEC10; imem[2] = 16'h0014; imem[3] = 16'hE301;
    idly = 1; ddly = 0;
    do_reset();
    nwr0 = nwr; nrd0 = nrd;
    spur = 1'b1;
    ok   = 1'b1;
    for (int s = 0; s < 4 && ok; s++) step_one(1'b0, ok);
    spur = 1'b0;
    chk("spur.A", 32'(dut.r_a), 32'd20);
    chk("spur.D", 32'(dut.r_d), 32'd7);
    chk("spur.PC", 32'(dut.r_pc), 32'd20);
    chk("spur.dmem_traffic", 32'((nwr - nwr0) + (nrd - nrd0)), 0);

    // ---- reset while MWRITE waits for its ack ----
    imem[0] = 16'h0007; imem[1] = 16'hEC10; imem[2] = 16'h0064; imem[3] = 16'hE308;
    idly = 0; ddly = 20;
    do_reset();
    nwr0 = nwr;
    ok   = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clk);
      if (dmem_req && dmem_we) ok = 1'b1;
    end
    chk("rstw.saw_mwrite", 32'(ok), 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rstw.dmem_req", 32'(dmem_req), 0);
    @(negedge clk);
    rst_n = 1'b1;
    spur  = 1'b1;  // late ack for the abandoned write
    #1;
    chk("rstw.imem_req", 32'(imem_req), 1);
    chk("rstw.imem_addr", 32'(imem_addr), 0);
    chk("rstw.dmem_req", 32'(dmem_req), 0);
    chk("rstw.A", 32'(dut.r_a), 0);
    chk("rstw.D", 32'(dut.r_d), 0);
    @(posedge clk);
    #1;
    spur = 1'b0;
    ddly = 0;
    ok   = 1'b1;
    for (int s = 0; s < 3 && ok; s++) step_one(1'b0, ok);
    if (ok) step_one(1'b0, ok);
    chk("rstw.rerun_A", 32'(dut.r_a), 32'd100);
    chk("rstw.rerun_PC", 32'(dut.r_pc), 32'd4);
    chk("rstw.nwrites", 32'(nwr - nwr0), 1);

    // ---- randomized programs against the reference model ----
    for (int prog = 0; prog < 20; prog++) begin
      for (int a = 0; a < 16; a++) begin
        if ($urandom_range(0, 2) == 0) begin
          imem[a] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 32767))
                                                : 16'($urandom_range(0, 15));
        end else begin
          imem[a] = {1'b1, 15'($urandom)};
        end
      end
      idly = $urandom_range(0, 2);
      ddly = $urandom_range(0, 2);
      do_reset();
      ma = 16'h0; md = 16'h0; mpc = 15'h0;
      mdm.delete();
      nwr0 = nwr;
      w    = 0;
      ok   = 1'b1;
      for (int s = 0; s < 40 && ok; s++) begin
        step_one(1'b1, ok);
        if (ok) begin
          chk($sformatf("rnd%0d.%0d.A", prog, s), 32'(dut.r_a), 32'(ma));
          chk($sformatf("rnd%0d.%0d.D", prog, s), 32'(dut.r_d), 32'(md));
          chk($sformatf("rnd%0d.%0d.PC", prog, s), 32'(dut.r_pc), 32'(mpc));
          if (m_wrote) begin
            w++;
            chk($sformatf("rnd%0d.%0d.nwr", prog, s), 32'(nwr - nwr0), 32'(w));
            chk($sformatf("rnd%0d.%0d.waddr", prog, s), 32'(wl_a[12'(nwr - 1)]), 32'(m_wa));
            chk($sformatf("rnd%0d.%0d.wdata", prog, s), 32'(wl_d[12'(nwr - 1)]), 32'(m_wd));
          end
        end
      end
      chk($sformatf("rnd%0d.total_writes", prog), 32'(nwr - nwr0), 32'(w));
    end

    chk("imem_hold_stable", 32'(iviol), 0);
    chk("dmem_hold_stable", 32'(dviol), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
